// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Enum includes GAP/VOTE states used only when PUF_MAJORITY_VOTE_EN is defined.
package puf_ctrl_pkg;

  localparam int CHAL_W_DEF   = 64;
  localparam int RESP_W_DEF   = 64;
  localparam int SETTLE_DEF   = 8;
  localparam int NUM_CHAL_DEF = 16;

  // Fibonacci taps 64,63,61,60 as a bit mask
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_OUTPUT,
    S_NEXT,
    S_FINISH,
    S_GAP,
    S_VOTE
  } state_t;

endpackage

// File: rtl/puf_lfsr.sv
// Fibonacci LFSR producing the challenge sequence.
// Shifts toward the MSB; a zero seed is replaced by 1 so it never locks up.
module puf_lfsr
  import puf_ctrl_pkg::*;
#(
  parameter int W = CHAL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);

  logic fb;

  assign fb = ^(value & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= W'(1);
    end else if (load) begin
      value <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      value <= {value[W-2:0], fb};
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives LFSR challenges into a PUF, captures responses, hands them downstream.
// Define PUF_MAJORITY_VOTE_EN for triple evaluation with bitwise majority vote.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int RESP_W     = RESP_W_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF,
  parameter int NUM_CHAL   = NUM_CHAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_enable,
  input  logic [RESP_W-1:0] puf_response,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [CHAL_W-1:0] resp_chal,
  output logic [7:0]        resp_index,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] IDX_LAST    = 8'(NUM_CHAL - 1);

  state_t            state, nstate;
  logic [7:0]        cnt;
  logic [7:0]        idx;
  logic              has_run;
  logic              load, step;
  logic [CHAL_W-1:0] lfsr_val;

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0]        ev;
  logic [RESP_W-1:0] r0, r1, r2;
`endif

  puf_lfsr #(.W(CHAL_W)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .seed (seed),
    .step (step),
    .value(lfsr_val)
  );

  always_comb begin
    nstate = state;
    load   = 1'b0;
    step   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load   = 1'b1;
          nstate = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) nstate = S_CAPTURE;
      end
`ifdef PUF_MAJORITY_VOTE_EN
      S_CAPTURE: nstate = (ev == 2'd2) ? S_VOTE : S_GAP;
      S_GAP:     nstate = S_SETTLE;
      S_VOTE:    nstate = S_OUTPUT;
`else
      S_CAPTURE: nstate = S_OUTPUT;
`endif
      S_OUTPUT: begin
        if (resp_ready) nstate = S_NEXT;
      end
      S_NEXT: begin
        if (idx == IDX_LAST) begin
          nstate = S_FINISH;
        end else begin
          step   = 1'b1;
          nstate = S_SETTLE;
        end
      end
      S_FINISH: nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      has_run    <= 1'b0;
      resp_data  <= '0;
      resp_chal  <= '0;
      resp_index <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      ev         <= '0;
      r0         <= '0;
      r1         <= '0;
      r2         <= '0;
`endif
    end else begin
      state <= nstate;
      cnt   <= (state == S_SETTLE && nstate == S_SETTLE) ? cnt + 8'd1 : '0;
      if (load) begin
        idx     <= '0;
        has_run <= 1'b1;
      end
      if (step) idx <= idx + 8'd1;
      if (state == S_CAPTURE) begin
        resp_chal  <= lfsr_val;
        resp_index <= idx;
`ifdef PUF_MAJORITY_VOTE_EN
        unique case (ev)
          2'd0:    r0 <= puf_response;
          2'd1:    r1 <= puf_response;
          default: r2 <= puf_response;
        endcase
        ev <= (ev == 2'd2) ? 2'd0 : ev + 2'd1;
`else
        resp_data  <= puf_response;
`endif
      end
`ifdef PUF_MAJORITY_VOTE_EN
      if (state == S_VOTE) resp_data <= (r0 & r1) | (r0 & r2) | (r1 & r2);
`endif
    end
  end

  // Challenge reads zero until the first run, then tracks the LFSR
  assign puf_challenge = has_run ? lfsr_val : '0;
  assign puf_enable    = (state == S_SETTLE);
  assign resp_valid    = (state == S_OUTPUT);
  assign busy          = (state != S_IDLE) && (state != S_FINISH);
  assign done          = (state == S_FINISH);

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural PUF and LFSR model.
// Expectations follow PUF_MAJORITY_VOTE_EN when it is defined.
module tb_puf_challenge_sequencer;

  localparam int CW = 64;
  localparam int RW = 64;
  localparam int S  = 8;
  localparam int N  = 4;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int LAT = 3 * (S + 2) + 1;
  localparam int NEV = 3;
`else
  localparam int LAT = S + 2;
  localparam int NEV = 1;
`endif

  logic          clk, rst, start;
  logic [CW-1:0] seed, puf_challenge, resp_chal;
  logic [RW-1:0] puf_response, resp_data;
  logic          puf_enable, resp_valid, resp_ready, busy, done;
  logic [7:0]    resp_index;

  puf_challenge_sequencer #(
    .CHAL_W(CW), .RESP_W(RW), .SETTLE_CYC(S), .NUM_CHAL(N)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .puf_challenge(puf_challenge), .puf_enable(puf_enable),
    .puf_response(puf_response), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_chal(resp_chal), .resp_index(resp_index),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [RW-1:0] d;
    logic [CW-1:0] c;
    logic [7:0]    i;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int nev = 0;
  logic en_prev = 1'b0;
  int rmode = 0;
  int stall_left = 0;
  bit stalled = 0;
  int stall_cycles = 0;
  int accepted = 0;
  int done_cnt = 0;
  bit held = 0;
  logic [RW-1:0] hd;
  logic [CW-1:0] hc;
  logic [7:0] hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mix(input logic [CW-1:0] c);
    return {c[31:0], c[63:32]} ^ 64'h0123_4567_89AB_CDEF ^ (c << 3);
  endfunction

  function automatic logic [CW-1:0] lnext(input logic [CW-1:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // PUF model: third evaluation of a challenge returns the complement
  assign puf_response = mix(puf_challenge) ^ ((nev == 3) ? {RW{1'b1}} : {RW{1'b0}});

  always @(negedge clk) begin
    if (rst) begin
      nev = 0;
      en_prev = 1'b0;
    end else begin
      if (puf_enable && !en_prev) nev = (nev >= NEV) ? 1 : nev + 1;
      en_prev = puf_enable;
    end
  end

  always @(negedge clk) begin
    if (rmode == 2 && resp_valid && resp_index == 8'd1 && !stalled) begin
      stalled = 1;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      stall_left--;
      resp_ready = 1'b0;
    end else if (rmode == 1) begin
      resp_ready = ($urandom % 4) != 0;
    end else begin
      resp_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      held = 0;
    end else begin
      if (done) done_cnt++;
      if (held) begin
        chk("hold_valid", 64'(resp_valid), 64'd1);
        chk("hold_data", resp_data, hd);
        chk("hold_chal", resp_chal, hc);
        chk("hold_index", 64'(resp_index), 64'(hi));
      end
      if (resp_valid) begin
        chk("enable_low_in_output", 64'(puf_enable), 64'd0);
        if (!resp_ready) begin
          held = 1;
          hd = resp_data;
          hc = resp_chal;
          hi = resp_index;
          if (rmode == 2 && resp_index == 8'd1) stall_cycles++;
        end else begin
          held = 0;
          accepted++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=idx%0d required=none", resp_index);
          end else begin
            e = q.pop_front();
            chk("resp_data", resp_data, e.d);
            chk("resp_chal", resp_chal, e.c);
            chk("resp_index", 64'(resp_index), 64'(e.i));
            chk("puf_evals", 64'(nev), 64'(NEV));
          end
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic push_run(input logic [CW-1:0] s);
    logic [CW-1:0] c;
    c = (s == '0) ? 64'd1 : s;
    for (int i = 0; i < N; i++) begin
      q.push_back('{mix(c), c, 8'(i)});
      c = lnext(c);
    end
  endtask

  task automatic kick(input logic [CW-1:0] s);
    int lat;
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    lat = 1;
    while (!resp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", 64'(lat), 64'(LAT));
  endtask

  task automatic run(input logic [CW-1:0] s, input int mode, input bit inj);
    int base, dn, t;
    rmode = mode;
    stalled = 0;
    stall_cycles = 0;
    base = accepted;
    dn = done_cnt;
    push_run(s);
    kick(s);
    if (inj) begin
      t = 0;
      while (!(accepted - base >= 2 && puf_enable) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      seed = {$urandom, $urandom};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == dn && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(dn + 1));
    chk("results_per_run", 64'(accepted - base), 64'(N));
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
    if (mode == 2) chk("stall_len", 64'(stall_cycles), 64'd5);
    rmode = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_challenge"}, puf_challenge, 64'd0);
    chk({tag, "_enable"}, 64'(puf_enable), 64'd0);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_data"}, resp_data, 64'd0);
    chk({tag, "_chal"}, resp_chal, 64'd0);
    chk({tag, "_index"}, 64'(resp_index), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic abort_run(input logic [CW-1:0] s);
    int base, dn, t;
    base = accepted;
    push_run(s);
    kick(s);
    t = 0;
    while (!(accepted - base >= 1 && puf_enable) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_in_settle", 64'(puf_enable), 64'd1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_zero("abort");
    q.delete();
    dn = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dn));
    chk("abort_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    resp_ready = 1'b1;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(64'h1, 0, 0);
    run(64'h0, 0, 0);
    run({$urandom, $urandom}, 2, 0);
    run({$urandom, $urandom}, 1, 1);
    abort_run({$urandom, $urandom});
    run({$urandom, $urandom}, 0, 0);
    for (int k = 0; k < 3; k++) run({$urandom, $urandom}, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
